// File: rtl/fric_client_regbus_if.sv
// Bus bundle between the FRIC switch slave port / register file and the
// fric_client_regbus endpoint. The endpoint uses the slave modport.
interface fric_client_regbus_if;
  logic [7:0]  fric_in;
  logic [7:0]  fric_out;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        err;
  logic        err_clr;

  modport slave (
    input  fric_in, reg_rdata, err_clr,
    output fric_out, reg_addr, reg_wdata, reg_wr, reg_rd, err
  );

  modport master (
    output fric_in, reg_rdata, err_clr,
    input  fric_out, reg_addr, reg_wdata, reg_wr, reg_rd, err
  );
endinterface

// File: rtl/fric_client_regbus.sv
// FRIC slave endpoint: decodes write/read request packets from the switch into
// single-cycle register bus accesses and returns write acks / read replies.
module fric_client_regbus #(
  parameter logic [3:0] ACK_W_TYPE = 4'h4,
  parameter logic [3:0] ACK_R_TYPE = 4'h5
) (
  input  logic                  clk,
  input  logic                  rst,
  fric_client_regbus_if.slave   bus
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] ADDR  = 4'd1;
  localparam logic [3:0] WD0   = 4'd2;
  localparam logic [3:0] WD1   = 4'd3;
  localparam logic [3:0] WR    = 4'd4;
  localparam logic [3:0] RD    = 4'd5;
  localparam logic [3:0] RWAIT = 4'd6;
  localparam logic [3:0] ACK0  = 4'd7;
  localparam logic [3:0] ACK1  = 4'd8;
  localparam logic [3:0] ACK2  = 4'd9;
  localparam logic [3:0] ACK3  = 4'd10;
  localparam logic [3:0] DRAIN = 4'd11;

  localparam logic [3:0] REQ_WR = 4'h2;
  localparam logic [3:0] REQ_RD = 4'h3;

  logic [3:0]  state;
  logic [7:0]  fric_inr;
  logic        is_rd;
  logic [15:0] rbuf;

  // Every output is a flop, so each transition loads the value the *next*
  // state presents; fric_out and the strobes default to 0 and are only
  // raised on the transitions that need them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      fric_inr      <= 8'h00;
      is_rd         <= 1'b0;
      rbuf          <= 16'h0000;
      bus.fric_out  <= 8'h00;
      bus.reg_addr  <= 8'h00;
      bus.reg_wdata <= 16'h0000;
      bus.reg_wr    <= 1'b0;
      bus.reg_rd    <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the
      // defaults below are overridden later in the same block, and the last
      // non-blocking assignment to a signal wins.
      fric_inr     <= bus.fric_in;
      bus.fric_out <= 8'h00;
      bus.reg_wr   <= 1'b0;
      bus.reg_rd   <= 1'b0;
      if (bus.err_clr) bus.err <= 1'b0;

      case (state)
        IDLE: begin
          if (fric_inr[7:4] == REQ_WR || fric_inr[7:4] == REQ_RD) begin
            is_rd <= fric_inr[4];
            state <= ADDR;
          end else if (fric_inr[7:4] != 4'h0) begin
            // Set is assigned after the clear above, so it wins.
            bus.err <= 1'b1;
            state   <= DRAIN;
          end
        end
        ADDR: begin
          bus.reg_addr <= fric_inr;
          if (is_rd) begin
            bus.reg_rd <= 1'b1;
            state      <= RD;
          end else begin
            state <= WD0;
          end
        end
        WD0: begin
          bus.reg_wdata[7:0] <= fric_inr;
          state              <= WD1;
        end
        WD1: begin
          bus.reg_wdata[15:8] <= fric_inr;
          bus.reg_wr          <= 1'b1;
          state               <= WR;
        end
        WR: begin
          bus.fric_out <= {ACK_W_TYPE, 4'h0};
          state        <= ACK0;
        end
        RD: begin
          state <= RWAIT;
        end
        RWAIT: begin
          rbuf         <= bus.reg_rdata;
          bus.fric_out <= {ACK_R_TYPE, 4'h0};
          state        <= ACK0;
        end
        ACK0: begin
          bus.fric_out <= bus.reg_addr;
          state        <= ACK1;
        end
        ACK1: begin
          if (is_rd) begin
            bus.fric_out <= rbuf[7:0];
            state        <= ACK2;
          end else begin
            state <= IDLE;
          end
        end
        ACK2: begin
          bus.fric_out <= rbuf[15:8];
          state        <= ACK3;
        end
        ACK3: begin
          state <= IDLE;
        end
        DRAIN: begin
          // Swallow the rest of a rejected packet so its payload bytes are
          // never mistaken for headers.
          if (fric_inr == 8'h00) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fric_client_regbus.sv
// Directed, table-driven bench for fric_client_regbus: one record per clock
// cycle holding the inputs driven in that cycle and the outputs expected then.
module tb_fric_client_regbus;

  logic clk;
  logic rst;
  fric_client_regbus_if bus();

  fric_client_regbus dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  fin;
    logic [15:0] rdata;
    logic        clr;
    logic [7:0]  out;
    logic        wr;
    logic        rd;
    logic        err;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] fin, input logic [15:0] rdata,
                     input logic clr, input logic [7:0] out, input logic wr,
                     input logic rd, input logic err, input logic [7:0] addr,
                     input logic [15:0] wdata);
    vec_t v;
    v.fin = fin; v.rdata = rdata; v.clr = clr; v.out = out;
    v.wr = wr; v.rd = rd; v.err = err; v.addr = addr; v.wdata = wdata;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs just after the rising edge, check mid-cycle.
  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    bus.fric_in   = v.fin;
    bus.reg_rdata = v.rdata;
    bus.err_clr   = v.clr;
    @(negedge clk);
    check("fric_out", idx, {8'h00, bus.fric_out}, {8'h00, v.out});
    check("reg_wr",   idx, {15'h0, bus.reg_wr},   {15'h0, v.wr});
    check("reg_rd",   idx, {15'h0, bus.reg_rd},   {15'h0, v.rd});
    check("err",      idx, {15'h0, bus.err},      {15'h0, v.err});
    if (v.wr || v.rd) check("reg_addr", idx, {8'h00, bus.reg_addr}, {8'h00, v.addr});
    if (v.wr)         check("reg_wdata", idx, bus.reg_wdata, v.wdata);
  endtask

  initial begin
    bus.fric_in   = 8'h00;
    bus.reg_rdata = 16'h0000;
    bus.err_clr   = 1'b0;
    rst           = 1'b0;

    //   fin    rdata     clr  out    wr rd err addr   wdata
    // Write 0x1234 to 0x1A; ack 0x40,0x1A at k+6/k+7.
    add(8'h20, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h1A, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h34, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h12, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 1, 0, 0, 8'h1A, 16'h1234);
    add(8'h00, 16'hDEAD, 0, 8'h40, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h1A, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    // Read 0x07, rdata 0xBEEF valid only at k+4.
    add(8'h30, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h07, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 1, 0, 8'h07, 16'h0000);
    add(8'h00, 16'hBEEF, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h50, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h07, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'hEF, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'hBE, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    // Illegal header 0x70 then read-looking payload: err, drain, then clear.
    add(8'h70, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h30, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h05, 16'hDEAD, 0, 8'h00, 0, 0, 1, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 1, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 1, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 1, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 1, 8'h00, 0, 0, 1, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    // Legal read of 0x42 after the error, rdata 0xA55A.
    add(8'h30, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h42, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 1, 0, 8'h42, 16'h0000);
    add(8'h00, 16'hA55A, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h50, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h42, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h5A, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'hA5, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    // Write 0xABCD to 0x80, then read 0x11 whose header lands as the ack clears.
    add(8'h20, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h80, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'hCD, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'hAB, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 1, 0, 0, 8'h80, 16'hABCD);
    add(8'h00, 16'hDEAD, 0, 8'h40, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h80, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h30, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h11, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 1, 0, 8'h11, 16'h0000);
    add(8'h00, 16'h0F0E, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h50, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h11, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h0E, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h0F, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    // Illegal header 0x90 with err_clr in its decode cycle: set wins.
    add(8'h90, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 1, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 1, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 1, 8'h00, 0, 0, 1, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fric_out",  -1, {8'h00, bus.fric_out}, 16'h0000);
    check("rst_reg_addr",  -1, {8'h00, bus.reg_addr}, 16'h0000);
    check("rst_reg_wdata", -1, bus.reg_wdata,         16'h0000);
    check("rst_reg_wr",    -1, {15'h0, bus.reg_wr},   16'h0000);
    check("rst_reg_rd",    -1, {15'h0, bus.reg_rd},   16'h0000);
    check("rst_err",       -1, {15'h0, bus.err},      16'h0000);
    rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Read of 0x07 interrupted by reset while ACK1 drives the address.
    tbl.delete();
    add(8'h30, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h07, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 1, 0, 8'h07, 16'h0000);
    add(8'h00, 16'hBEEF, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h50, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h07, 0, 0, 0, 8'h00, 16'h0000);
    foreach (tbl[i]) apply(tbl[i], 100 + i);
    #1 rst = 1'b0;
    #1;
    check("async_rst_fric_out", 200, {8'h00, bus.fric_out}, 16'h0000);
    check("async_rst_reg_wr",   200, {15'h0, bus.reg_wr},   16'h0000);
    check("async_rst_reg_rd",   200, {15'h0, bus.reg_rd},   16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // No partial reply after release, then a write with a 0x25 header.
    tbl.delete();
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h25, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h3C, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h01, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 1, 0, 0, 8'h3C, 16'h0001);
    add(8'h00, 16'hDEAD, 0, 8'h40, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h3C, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    add(8'h00, 16'hDEAD, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000);
    foreach (tbl[i]) apply(tbl[i], 300 + i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
